fifo_mem_responder: RTL
=======================

// Module: fifo_mem_responder
// PURPOSE
//  Responder end of the AXI_FIFO request/stream interface: serves READ_REQ bursts from a local
//  word memory and absorbs WRITE_REQ bursts into it. Stands in for the AXI DMA bridge so a
//  bitstream wrapper can run standalone in simulation or on-chip BRAM. Read and write channels
//  run independently and concurrently.
// PARAMETERS
//  AW        10  word-address bits; memory depth = 2**AW words of 32 bits
//  STALL_SEED 16'hACE1  LFSR seed, used only with FIFO_STALL_EN
// PORTS
//  CLK          in   1   clock
//  RST_X        in   1   asynchronous active-low reset
//  READ_ADDR    in   32  byte address of read burst (bits [1:0] ignored)
//  READ_COUNT   in   16  words in read burst
//  READ_REQ     in   1   read request pulse, sampled when READ_BUSY=0
//  READ_BUSY    out  1   read burst in progress
//  READ_DATA    out  32  read word
//  READ_VALID   out  1   READ_DATA valid
//  READ_READY   in   1   initiator accepts READ_DATA
//  WRITE_ADDR   in   32  byte address of write burst (bits [1:0] ignored)
//  WRITE_COUNT  in   16  words in write burst
//  WRITE_REQ    in   1   write request pulse, sampled when WRITE_BUSY=0
//  WRITE_BUSY   out  1   write burst in progress
//  WRITE_DATA   in   32  write word
//  WRITE_VALID  in   1   WRITE_DATA valid
//  WRITE_READY  out  1   responder accepts WRITE_DATA
//  HOST_WE      in   1   backdoor write (preload/dump), lowest priority vs burst write
//  HOST_ADDR    in   AW  backdoor word address
//  HOST_WDATA   in   32  backdoor write data
//  HOST_RDATA   out  32  backdoor read data, 1-cycle latency
// BEHAVIOUR
//  - Reset: READ_BUSY=0, READ_VALID=0, READ_DATA=0, WRITE_BUSY=0, WRITE_READY=0, HOST_RDATA=0;
//    memory contents not reset. Reset mid-burst aborts both channels, buffered words dropped.
//  - Read FSM R_IDLE->R_RUN->R_DRAIN->R_IDLE. R_IDLE: REQ && COUNT!=0 latches word addr
//    ADDR[AW+1:2], remaining=COUNT; BUSY=1 next cycle. COUNT==0 ignored (no BUSY).
//  - R_RUN: issue one memory read per cycle while 2-entry skid buffer not full; addr+1 mod 2**AW
//    (wrap). First READ_VALID 2 cycles after accepted REQ. Word transfers on VALID&&READY;
//    VALID never drops nor DATA changes while READY=0. Last issue -> R_DRAIN; when buffer
//    empties -> R_IDLE, BUSY=0 same cycle as last handshake+1.
//  - Write FSM W_IDLE->W_RUN->W_IDLE. W_RUN: WRITE_READY=1; each VALID&&READY writes word,
//    addr+1 with wrap; after COUNT words -> W_IDLE, READY=0, BUSY=0 next cycle. COUNT==0 ignored.
//  - REQ while BUSY=1 ignored (not queued). REQ same cycle burst ends ignored.
//  - Simultaneous burst read and burst write to same word: read-first (old data returned).
//  - HOST_WE and burst write same cycle: burst write wins, host write dropped.
//  - Throughput: 1 word/cycle each channel with READY/VALID held high.
// CONFIGURATION
//  FIFO_STALL_EN defined: 16-bit LFSR (seed STALL_SEED, x^16+x^14+x^13+x^11) advances every
//    cycle; when lfsr[1:0]==2'b00, read issue and WRITE_READY are suppressed that cycle. Handshake
//    rules unchanged. Undefined: no stalls, LFSR absent.
// STRUCTURE
//  - fifo_mem_pkg: rd_state_t, wr_state_t enums; WORD_W=32; CNT_W=16.
//  - Sub-module fifo_mem_skid: 2-entry valid/ready buffer absorbing 1-cycle memory latency.
//  - Memory: simple dual-port array (burst write/host write port, burst read port) + host read.
// TESTING
//  1 Preload mem[0..3]=1..4 via HOST; READ_REQ addr 0 count 4, READY=1 -> 1,2,3,4 on
//    consecutive cycles, first VALID 2 cycles after REQ, BUSY falls after 4th.
//  2 Same read, READY toggled 1010.. -> 4 words, none duplicated/lost, DATA stable when stalled.
//  3 WRITE_REQ addr 'h10 count 3, data A,B,C with VALID gaps -> HOST reads mem[4..6]=A,B,C.
//  4 Read addr (2**AW-2)*4 count 4 -> words from 2**AW-2, 2**AW-1, 0, 1 (wrap).
//  5 Concurrent read/write of mem[8] during bursts -> read gets old value, later host read new.
//  6 Assert RST_X=0 mid-read -> VALID/BUSY 0 immediately; new REQ after reset works; count 0 ignored.

Source files
------------

// File: rtl/fifo_mem_pkg.sv
// Shared types and widths for the fifo_mem_responder slice.
package fifo_mem_pkg;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RUN,
    R_DRAIN
  } rd_state_t;

  typedef enum logic {
    W_IDLE,
    W_RUN
  } wr_state_t;

endpackage

// File: rtl/fifo_mem_skid.sv
// Two-entry valid/ready buffer that catches words coming back from the
// one-cycle-latency memory read. The head entry drives the output directly,
// so the presented word never changes while the consumer stalls. The caller
// only pushes when a slot is guaranteed free (see the credit check in the top).
module fifo_mem_skid
  import fifo_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        count
);

  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] head_q, head_d;
  logic [WORD_W-1:0] tail_q, tail_d;
  logic              pop;

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;
  assign pop       = out_valid && out_ready;

  // Push/pop bookkeeping: the head only moves on a pop or when the buffer was empty.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case ({in_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_data;
        else                 tail_d = in_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  // Buffer state registers; words are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/fifo_mem_responder.sv
// Responder end of the AXI_FIFO request/stream interface, backed by a local
// word memory. Read and write burst channels run independently.
// Optional macro FIFO_STALL_EN adds pseudo-random stalls of read issue and
// WRITE_READY driven by a 16-bit LFSR.
module fifo_mem_responder
  import fifo_mem_pkg::*;
#(
  parameter int          AW         = 10,
  parameter logic [15:0] STALL_SEED = 16'hACE1
)
(
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [31:0]       READ_ADDR,
  input  logic [CNT_W-1:0]  READ_COUNT,
  input  logic              READ_REQ,
  output logic              READ_BUSY,
  output logic [WORD_W-1:0] READ_DATA,
  output logic              READ_VALID,
  input  logic              READ_READY,
  input  logic [31:0]       WRITE_ADDR,
  input  logic [CNT_W-1:0]  WRITE_COUNT,
  input  logic              WRITE_REQ,
  output logic              WRITE_BUSY,
  input  logic [WORD_W-1:0] WRITE_DATA,
  input  logic              WRITE_VALID,
  output logic              WRITE_READY,
  input  logic              HOST_WE,
  input  logic [AW-1:0]     HOST_ADDR,
  input  logic [WORD_W-1:0] HOST_WDATA,
  output logic [WORD_W-1:0] HOST_RDATA
);

  localparam int DEPTH = 1 << AW;

  logic [WORD_W-1:0] mem [DEPTH];

  rd_state_t         rd_state_q, rd_state_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]  rd_rem_q, rd_rem_d;
  logic              rd_pend_q, rd_pend_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              rd_issue;
  logic              rd_pop;
  logic [1:0]        skid_count;
  logic [2:0]        rd_occ;

  wr_state_t         wr_state_q, wr_state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  wr_rem_q, wr_rem_d;
  logic              wr_fire;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] host_rdata_q, host_rdata_d;

  logic              stall;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{READ_ADDR[31:AW+2], READ_ADDR[1:0],
                              WRITE_ADDR[31:AW+2], WRITE_ADDR[1:0]};

`ifdef FIFO_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^16+x^14+x^13+x^11, free running.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, restarted from the seed on reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) lfsr_q <= STALL_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall       = 1'b0;
`endif

  // Words that will sit in the skid buffer after this edge, counting the read in flight.
  assign rd_pop      = READ_VALID && READ_READY;
  assign rd_occ      = {1'b0, skid_count} + {2'b00, rd_pend_q} - {2'b00, rd_pop};
  assign READ_BUSY   = (rd_state_q != R_IDLE);
  assign mem_rdata_d = mem[rd_addr_q];

  // Read burst sequencing: accept a request, issue one read per free buffer slot, then drain.
  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_rem_d   = rd_rem_q;
    rd_issue   = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        if (READ_REQ && (READ_COUNT != '0)) begin
          rd_addr_d  = READ_ADDR[AW+1:2];
          rd_rem_d   = READ_COUNT;
          rd_state_d = R_RUN;
        end
      end
      R_RUN: begin
        if (!stall && (rd_occ < 3'd2)) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + AW'(1);
          rd_rem_d  = rd_rem_q - CNT_W'(1);
          if (rd_rem_q == CNT_W'(1)) rd_state_d = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (rd_occ == 3'd0) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    rd_pend_d = rd_issue;
  end

  // Read channel state registers; reset aborts any burst in progress.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_rem_q   <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_rem_q   <= rd_rem_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // Synchronous memory read port; sees the pre-write contents on a same-cycle write.
  always_ff @(posedge CLK) begin
    if (rd_issue) mem_rdata_q <= mem_rdata_d;
  end

  fifo_mem_skid u_skid (
    .clk       (CLK),
    .rst_n     (RST_X),
    .in_valid  (rd_pend_q),
    .in_data   (mem_rdata_q),
    .out_valid (READ_VALID),
    .out_data  (READ_DATA),
    .out_ready (READ_READY),
    .count     (skid_count)
  );

  assign WRITE_BUSY  = (wr_state_q == W_RUN);
  assign WRITE_READY = (wr_state_q == W_RUN) && !stall;
  assign wr_fire     = WRITE_VALID && WRITE_READY;

  // Write burst sequencing: accept a request, then count accepted words down to zero.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_rem_d   = wr_rem_q;
    case (wr_state_q)
      W_IDLE: begin
        if (WRITE_REQ && (WRITE_COUNT != '0)) begin
          wr_addr_d  = WRITE_ADDR[AW+1:2];
          wr_rem_d   = WRITE_COUNT;
          wr_state_d = W_RUN;
        end
      end
      W_RUN: begin
        if (wr_fire) begin
          wr_addr_d = wr_addr_q + AW'(1);
          wr_rem_d  = wr_rem_q - CNT_W'(1);
          if (wr_rem_q == CNT_W'(1)) wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write channel state registers.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_rem_q   <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_rem_q   <= wr_rem_d;
    end
  end

  // Single write port shared by burst and host; the burst owns it whenever it fires.
  always_comb begin
    mem_we    = wr_fire || HOST_WE;
    mem_waddr = wr_fire ? wr_addr_q  : HOST_ADDR;
    mem_wdata = wr_fire ? WRITE_DATA : HOST_WDATA;
  end

  // Memory write port, contents deliberately not reset.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign host_rdata_d = mem[HOST_ADDR];
  assign HOST_RDATA   = host_rdata_q;

  // Host backdoor read register, one cycle of latency.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) host_rdata_q <= '0;
    else        host_rdata_q <= host_rdata_d;
  end

endmodule
